// File: rtl/two_bit_adder.sv
// Registered ripple-carry adder with carry-in: {carry,sum} = a + b + cin, one cycle latency.
// Results only load on in_valid cycles, so idle-cycle inputs (even X/Z) never reach the outputs.

module two_bit_adder_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module two_bit_adder #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    two_bit_adder_fa u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  // sum/carry hold across idle cycles; out_valid marks only the cycle after an in_valid edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= s;
        carry <= c[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_two_bit_adder.sv
// Directed self-checking bench for two_bit_adder: reset, table, carry-in, hold,
// exhaustive back-to-back and mid-stream asynchronous reset.

module tb_two_bit_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] a;
  logic [1:0] b;
  logic       cin;
  logic [1:0] sum;
  logic       carry;
  logic       out_valid;

  int tests_run;
  int tests_failed;

  localparam logic [1:0] TAB_A   [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  localparam logic [1:0] TAB_B   [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
  localparam logic [1:0] TAB_SUM [4] = '{2'b01, 2'b11, 2'b01, 2'b10};
  localparam logic       TAB_C   [4] = '{1'b0,  1'b0,  1'b1,  1'b1};

  localparam logic [1:0] CI_A   [3] = '{2'b11, 2'b11, 2'b00};
  localparam logic [1:0] CI_B   [3] = '{2'b00, 2'b11, 2'b00};
  localparam logic [1:0] CI_SUM [3] = '{2'b00, 2'b11, 2'b01};
  localparam logic       CI_C   [3] = '{1'b1,  1'b1,  1'b0};

  two_bit_adder #(.WIDTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .carry     (carry),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a = 2'b00; b = 2'b00; cin = 1'b0;
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a   = 2'($urandom_range(0, 3));
    b   = 2'($urandom_range(0, 3));
    cin = 1'($urandom_range(0, 1));
    #1;
    tests_run++;
    if ({out_valid, carry, sum} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_immediate: got valid=%b carry=%b sum=%b, expected 0 0 00",
               out_valid, carry, sum);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({out_valid, carry, sum} !== 4'b0000) begin
        tests_failed++;
        $display("[TB] FAIL reset_edge[%0d]: got valid=%b carry=%b sum=%b, expected 0 0 00",
                 i, out_valid, carry, sum);
      end
      a   = 2'($urandom_range(0, 3));
      b   = 2'($urandom_range(0, 3));
      cin = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_table();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a = TAB_A[i]; b = TAB_B[i]; cin = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if ({out_valid, carry, sum} !== {1'b1, TAB_C[i], TAB_SUM[i]}) begin
        tests_failed++;
        $display("[TB] FAIL table[%0d]: got valid=%b carry=%b sum=%b, expected valid=1 carry=%b sum=%b",
                 i, out_valid, carry, sum, TAB_C[i], TAB_SUM[i]);
      end
    end
  endtask

  task automatic test_carry_in();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = CI_A[i]; b = CI_B[i]; cin = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if ({out_valid, carry, sum} !== {1'b1, CI_C[i], CI_SUM[i]}) begin
        tests_failed++;
        $display("[TB] FAIL carry_in[%0d]: got valid=%b carry=%b sum=%b, expected valid=1 carry=%b sum=%b",
                 i, out_valid, carry, sum, CI_C[i], CI_SUM[i]);
      end
    end
  endtask

  task automatic test_hold();
    in_valid = 1'b1;
    a = 2'b11; b = 2'b11; cin = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, carry, sum} !== 4'b1110) begin
      tests_failed++;
      $display("[TB] FAIL hold_load: got valid=%b carry=%b sum=%b, expected valid=1 carry=1 sum=10",
               out_valid, carry, sum);
    end
    in_valid = 1'b0;
    a = 2'b01; b = 2'b01; cin = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, carry, sum} !== 4'b0110) begin
      tests_failed++;
      $display("[TB] FAIL hold_idle: got valid=%b carry=%b sum=%b, expected valid=0 carry=1 sum=10",
               out_valid, carry, sum);
    end
    // idle-cycle X inputs must be ignored
    a = 2'bxx; b = 2'bzz; cin = 1'bx;
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, carry, sum} !== 4'b0110) begin
      tests_failed++;
      $display("[TB] FAIL hold_xin: got valid=%b carry=%b sum=%b, expected valid=0 carry=1 sum=10",
               out_valid, carry, sum);
    end
  endtask

  task automatic test_exhaustive();
    logic [2:0] expected;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      a   = 2'(i >> 3);
      b   = 2'(i >> 1);
      cin = 1'(i);
      expected = {1'b0, a} + {1'b0, b} + {2'b00, cin};
      @(posedge clk); #1;
      tests_run++;
      if ({out_valid, carry, sum} !== {1'b1, expected}) begin
        tests_failed++;
        $display("[TB] FAIL exhaustive[a=%b b=%b cin=%b]: got valid=%b carry=%b sum=%b, expected valid=1 carry=%b sum=%b",
                 a, b, cin, out_valid, carry, sum, expected[2], expected[1:0]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [2:0] expected;
    for (int i = 20; i < 26; i++) begin
      in_valid = 1'b1;
      a   = 2'(i >> 3);
      b   = 2'(i >> 1);
      cin = 1'(i);
      expected = {1'b0, a} + {1'b0, b} + {2'b00, cin};
      @(posedge clk); #1;
      tests_run++;
      if ({out_valid, carry, sum} !== {1'b1, expected}) begin
        tests_failed++;
        $display("[TB] FAIL midstream_pre[%0d]: got valid=%b carry=%b sum=%b, expected valid=1 carry=%b sum=%b",
                 i, out_valid, carry, sum, expected[2], expected[1:0]);
      end
    end
    a = 2'b11; b = 2'b11; cin = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, carry, sum} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL midstream_async: got valid=%b carry=%b sum=%b, expected 0 0 00",
               out_valid, carry, sum);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, carry, sum} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL midstream_held: got valid=%b carry=%b sum=%b, expected 0 0 00",
               out_valid, carry, sum);
    end
    #2;
    rst_n = 1'b1;
    a = 2'b01; b = 2'b01; cin = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, carry, sum} !== 4'b1011) begin
      tests_failed++;
      $display("[TB] FAIL midstream_recover: got valid=%b carry=%b sum=%b, expected valid=1 carry=0 sum=11",
               out_valid, carry, sum);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_table();
    test_carry_in();
    test_hold();
    test_exhaustive();
    test_midstream_reset();
    in_valid = 1'b0;
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
